uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 41 ++++
 rtl/uart_tx.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART constants: FSM state encoding and default frame/baud.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DEFAULT_BIT_WIDTH = 8;
    localparam int UART_DEFAULT_CLK_DIV   = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_baud_tick
// Brief   : Baud counter wrapping at clk_div-1 with a one-cycle tick on wrap.
// Revision: 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int clk_div = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int              CW       = $clog2(clk_div);
    localparam logic [CW-1:0]   CNT_LAST = CW'(clk_div - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = !clear && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_tx
// Brief   : FIFO-fed 8N1-style serial transmitter (start, LSB-first data, stop).
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int bit_width = UART_DEFAULT_BIT_WIDTH,
    parameter int clk_div   = UART_DEFAULT_CLK_DIV
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    output logic                 read,
    input  logic [bit_width-1:0] read_data,
    output logic                 tx,
    output logic                 busy
);

    localparam int              BCW      = $clog2(bit_width + 1);
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(bit_width - 1);

    logic [2:0]           state_q, state_d;
    logic [bit_width-1:0] shift_q, shift_d, shift_nxt;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 baud_clear;
    logic                 baud_tick;

    // Pop is gated by reset so the fifo is never drained while held in reset.
    assign read       = rst && (state_q == ST_IDLE) && !fifo_empty;
    assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_FETCH);
    assign tx         = tx_q;
    // The pop cycle itself counts as busy; from FETCH on busy is purely the flop.
    assign busy       = busy_q || read;

    uart_baud_tick #(
        .clk_div (clk_div)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear),
        .tick  (baud_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        shift_nxt = shift_q >> 1;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (read) begin
                    state_d = ST_FETCH;
                    busy_d  = 1'b1;
                end
            end
            ST_FETCH: begin
                shift_d   = read_data;
                bit_cnt_d = '0;
                tx_d      = 1'b0;
                state_d   = ST_START;
            end
            ST_START: begin
                if (baud_tick) begin
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        shift_d   = shift_nxt;
                        tx_d      = shift_nxt[0];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (baud_tick) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

endmodule
`default_nettype wire
